prbs4_checker: RTL and testbench
================================

Name: prbs4_checker

Overview:
- Serial receive-side checker for the 4-bit Fibonacci LFSR stream. Polynomial x^4+x^3+1, feedback s3' = s0 ^ s1, shift toward bit 0, serial output = s0. Period 15.
- Self-synchronises to the incoming bit stream, declares lock, then counts bit errors against a free-running local replica.
- Sits at the far end of the LFSR serial link and is used for link/BIST verification.

Parameters:
- LOCK_THRESH, 8: consecutive correct predictions in VERIFY required to enter LOCKED (range 1..15).
- LOSS_THRESH, 4: consecutive mismatches in LOCKED that force re-acquisition (range 1..15).
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  checker enable. 0 forces state ACQ and clears the acquisition counters; err_cnt is held.
- din  in  1  received serial bit.
- din_valid  in  1  din qualifier; state advances only on cycles where en=1 and din_valid=1.
- clr_err  in  1  synchronous clear of err_cnt and zero_fault.
- locked  out  1  high while in state LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_cnt  out  ERR_W  saturating count of LOCKED mismatches.
- zero_fault  out  1  sticky flag: all-zero history detected (illegal LFSR state).

Behaviour:
- Reset (rst=0, asynchronous): hist=4'b0000, state=ACQ, fill_cnt=0, match_cnt=0, miss_cnt=0. Outputs: locked=0, err_pulse=0, err_cnt=0, zero_fault=0.
- hist[3:0] is the history register; hist[0] holds the oldest bit. pred = hist[0] ^ hist[1].
- A "valid cycle" is one with en=1 and din_valid=1. No state changes on any other cycle. err_pulse is 0 on every non-valid cycle.
- ACQ: each valid cycle does hist <= {din, hist[3:1]} and fill_cnt++.
  - On the 4th valid cycle, go to VERIFY with match_cnt=0.
  - Exception: if the new hist value is 4'b0000, set zero_fault=1, stay in ACQ and reset fill_cnt to 0.
- VERIFY: each valid cycle does hist <= {din, hist[3:1]}.
  - din==pred: match_cnt++. When match_cnt reaches LOCK_THRESH, go to LOCKED (locked=1 from the following cycle) and set miss_cnt=0.
  - din!=pred: match_cnt=0 and stay in VERIFY.
  - New hist == 0: set zero_fault=1 and go to ACQ.
- LOCKED: each valid cycle does hist <= {pred, hist[3:1]}, so the local replica free-runs and each line error is counted exactly once.
  - din!=pred: err_pulse=1 in the next cycle, err_cnt++ (saturates at all-ones), miss_cnt++. When miss_cnt reaches LOSS_THRESH, go to ACQ with fill_cnt=0 and locked=0.
  - din==pred: miss_cnt=0.
- All outputs are registered; latency from the valid input edge to output is 1 cycle.
- clr_err=1 clears err_cnt and zero_fault on that edge and takes priority over an increment on the same edge. State and lock are unaffected.
- en deasserted mid-operation: state=ACQ, fill/match/miss counters = 0, locked=0 next cycle. hist is kept but is overwritten during re-acquisition.
- Rst asserted mid-operation: immediate return to the reset values above.

Optional Feature:
- Macro: PRBS4_CHECKER_BITCNT_EN.
- Defined: adds output bit_cnt [31:0], which increments on every valid cycle while LOCKED, wraps at 2^32, and is cleared by clr_err and by rst. err_cnt/bit_cnt then gives the BER.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Clean lock: feed generator stream from seed 4'b1000 (bits 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 repeating), din_valid=1 every cycle -> locked rises 1 cycle after the 12th valid bit; err_cnt stays 0 over 100 bits.
- Single error: once locked, invert one bit -> exactly one err_pulse, err_cnt=1, locked stays 1, and the following bits report no errors.
- Loss of lock: once locked, feed 4 consecutive inverted bits -> err_cnt=4, locked falls on the 4th; resuming the clean stream relocks after 12 more valid bits.
- Zero fault: feed constant 0 -> zero_fault=1 after the 4th bit, locked never asserts; clr_err=1 -> zero_fault=0 and err_cnt=0.
- Gapped valid and disable: din_valid toggling 1,0,1,0 -> same lock point counted in valid bits only; en=0 while locked -> locked=0 next cycle and err_cnt held.
- Saturation and reset: with ERR_W=4, inject 20 isolated errors -> err_cnt=15; pulse rst low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prbs4_checker.sv
// Self-synchronising checker for the x^4+x^3+1 PRBS stream: acquires, verifies, locks, counts bit errors.
// Optional bit_cnt output (locked-cycle counter for BER) enabled by PRBS4_CHECKER_BITCNT_EN.
module prbs4_checker #(
  parameter int unsigned LOCK_THRESH = 8,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             zero_fault
`ifdef PRBS4_CHECKER_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [3:0]       hist_q, hist_n;
  logic [CNT_W-1:0] fill_q, fill_n;
  logic [CNT_W-1:0] match_q, match_n;
  logic [CNT_W-1:0] miss_q, miss_n;
  logic [3:0]       shifted;
  logic             pred;
  logic             err_hit;
  logic             zero_set;
  logic             locked_n;
  logic             err_pulse_n;
  logic [ERR_W-1:0] err_cnt_n;
  logic             zero_fault_n;
`ifdef PRBS4_CHECKER_BITCNT_EN
  logic [31:0]      bit_cnt_n;
`endif

  assign pred    = hist_q[0] ^ hist_q[1];
  assign shifted = {din, hist_q[3:1]};

  // Next-state, counter and output computation
  always_comb begin
    state_n  = state_q;
    hist_n   = hist_q;
    fill_n   = fill_q;
    match_n  = match_q;
    miss_n   = miss_q;
    err_hit  = 1'b0;
    zero_set = 1'b0;

    if (!en) begin
      state_n = ACQ;
      fill_n  = '0;
      match_n = '0;
      miss_n  = '0;
    end else if (din_valid) begin
      case (state_q)
        ACQ: begin
          hist_n = shifted;
          fill_n = fill_q + CNT_W'(1);
          if (fill_q == CNT_W'(3)) begin
            fill_n = '0;
            if (shifted == 4'b0000) begin
              zero_set = 1'b1;
            end else begin
              state_n = VERIFY;
              match_n = '0;
            end
          end
        end
        VERIFY: begin
          hist_n = shifted;
          if (shifted == 4'b0000) begin
            zero_set = 1'b1;
            state_n  = ACQ;
            fill_n   = '0;
          end else if (din == pred) begin
            match_n = match_q + CNT_W'(1);
            if (match_q == CNT_W'(LOCK_THRESH - 1)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          // Replica free-runs so a line error never corrupts later predictions
          hist_n = {pred, hist_q[3:1]};
          if (din != pred) begin
            err_hit = 1'b1;
            miss_n  = miss_q + CNT_W'(1);
            if (miss_q == CNT_W'(LOSS_THRESH - 1)) begin
              state_n = ACQ;
              fill_n  = '0;
            end
          end else begin
            miss_n = '0;
          end
        end
        default: begin
          state_n = ACQ;
          fill_n  = '0;
        end
      endcase
    end

    locked_n    = (state_n == LOCKED);
    err_pulse_n = err_hit;

    // clr_err wins over a same-edge increment
    err_cnt_n = err_cnt;
    if (clr_err) begin
      err_cnt_n = '0;
    end else if (err_hit && !(&err_cnt)) begin
      err_cnt_n = err_cnt + ERR_W'(1);
    end

    zero_fault_n = clr_err ? 1'b0 : (zero_fault | zero_set);

`ifdef PRBS4_CHECKER_BITCNT_EN
    bit_cnt_n = bit_cnt;
    if (clr_err) begin
      bit_cnt_n = '0;
    end else if (en && din_valid && state_q == LOCKED) begin
      bit_cnt_n = bit_cnt + 32'd1;
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ACQ;
      hist_q     <= 4'b0000;
      fill_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      zero_fault <= 1'b0;
`ifdef PRBS4_CHECKER_BITCNT_EN
      bit_cnt    <= '0;
`endif
    end else begin
      state_q    <= state_n;
      hist_q     <= hist_n;
      fill_q     <= fill_n;
      match_q    <= match_n;
      miss_q     <= miss_n;
      locked     <= locked_n;
      err_pulse  <= err_pulse_n;
      err_cnt    <= err_cnt_n;
      zero_fault <= zero_fault_n;
`ifdef PRBS4_CHECKER_BITCNT_EN
      bit_cnt    <= bit_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: m-sequence based reference model plus directed link scenarios.
module tb_prbs4_checker;

  localparam int LOCK_T = 8;
  localparam int LOSS_T = 4;
  localparam int M_ACQ  = 0;
  localparam int M_VER  = 1;
  localparam int M_LCK  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, err_pulse, zero_fault;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4, zero_fault4;
  logic [3:0]  err_cnt4;
`ifdef PRBS4_CHECKER_BITCNT_EN
  logic [31:0] bit_cnt, bit_cnt4;
`endif

  prbs4_checker #(.LOCK_THRESH(8), .LOSS_THRESH(4), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .zero_fault(zero_fault)
`ifdef PRBS4_CHECKER_BITCNT_EN
    , .bit_cnt(bit_cnt)
`endif
  );

  prbs4_checker #(.LOCK_THRESH(8), .LOSS_THRESH(4), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .zero_fault(zero_fault4)
`ifdef PRBS4_CHECKER_BITCNT_EN
    , .bit_cnt(bit_cnt4)
`endif
  );

  initial forever #5 clk = ~clk;

  // Period-15 m-sequence from seed 4'b1000
  bit seqv [15] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};

  int     checks = 0;
  int     errors = 0;
  int     gi = 0;
  // Model state: mode, counters, last four received bits (q[0] oldest), replica position
  int     mode = M_ACQ;
  int     fill = 0, match = 0, miss = 0, p = 0, errs = 0;
  bit     zf = 1'b0, pulse = 1'b0;
  longint bitc = 0;
  int     q [4] = '{0,0,0,0};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int locate();
    for (int k = 0; k < 15; k++)
      if (seqv[k] == q[0] && seqv[(k+1)%15] == q[1] && seqv[(k+2)%15] == q[2] && seqv[(k+3)%15] == q[3])
        return k;
    return -1;
  endfunction

  function automatic bit all_zero();
    return (q[0] == 0 && q[1] == 0 && q[2] == 0 && q[3] == 0);
  endfunction

  task automatic push(input int d);
    q[0] = q[1]; q[1] = q[2]; q[2] = q[3]; q[3] = d;
  endtask

  task automatic model_reset();
    mode = M_ACQ; fill = 0; match = 0; miss = 0; p = 0;
    errs = 0; zf = 1'b0; pulse = 1'b0; bitc = 0;
    q = '{0,0,0,0};
  endtask

  // Reference: a valid stream must continue the m-sequence from its last four bits
  task automatic model_step();
    int pp;
    int expb;
    int d;
    if (!rst) begin
      model_reset();
      return;
    end
    d = int'(din);
    pulse = 1'b0;
    if (!en) begin
      mode = M_ACQ; fill = 0; match = 0; miss = 0;
    end else if (din_valid) begin
      case (mode)
        M_ACQ: begin
          push(d);
          fill++;
          if (fill == 4) begin
            fill = 0;
            if (all_zero()) zf = 1'b1;
            else begin mode = M_VER; match = 0; end
          end
        end
        M_VER: begin
          pp = locate();
          expb = int'(seqv[(pp+4)%15]);
          push(d);
          if (all_zero()) begin
            zf = 1'b1; mode = M_ACQ; fill = 0;
          end else if (d == expb) begin
            match++;
            if (match == LOCK_T) begin mode = M_LCK; miss = 0; p = locate(); end
          end else begin
            match = 0;
          end
        end
        default: begin
          expb = int'(seqv[(p+4)%15]);
          p = (p + 1) % 15;
          bitc = (bitc + 1) % 64'h1_0000_0000;
          if (d != expb) begin
            pulse = 1'b1; errs++; miss++;
            if (miss == LOSS_T) begin mode = M_ACQ; fill = 0; end
          end else begin
            miss = 0;
          end
        end
      endcase
    end
    if (clr_err) begin errs = 0; zf = 1'b0; bitc = 0; end
  endtask

  // Compare DUT outputs against the model every cycle
  initial forever begin
    @(negedge clk);
    check("locked", 64'(locked), 64'(mode == M_LCK));
    check("err_pulse", 64'(err_pulse), 64'(pulse));
    check("err_cnt", 64'(err_cnt), 64'((errs > 65535) ? 65535 : errs));
    check("zero_fault", 64'(zero_fault), 64'(zf));
    check("locked4", 64'(locked4), 64'(mode == M_LCK));
    check("err_cnt4", 64'(err_cnt4), 64'((errs > 15) ? 15 : errs));
`ifdef PRBS4_CHECKER_BITCNT_EN
    check("bit_cnt", 64'(bit_cnt), 64'(bitc));
`endif
  end

  task automatic drive(input logic e, input logic v, input logic d, input logic c);
    en = e; din_valid = v; din = d; clr_err = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input bit inv);
    drive(1'b1, 1'b1, logic'(seqv[gi % 15] ^ inv), 1'b0);
    gi++;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, logic'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    #12 rst = 1'b1;
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    check("reset_zero_fault", 64'(zero_fault), 64'd0);

    // Clean lock: locked visible right after the 12th valid bit
    gi = 0;
    for (int i = 0; i < 11; i++) send(1'b0);
    check("lock_pre12", 64'(locked), 64'd0);
    send(1'b0);
    check("lock_at12", 64'(locked), 64'd1);
    for (int i = 0; i < 88; i++) send(1'b0);
    check("clean_err_cnt", 64'(err_cnt), 64'd0);
    check("clean_locked", 64'(locked), 64'd1);
`ifdef PRBS4_CHECKER_BITCNT_EN
    check("clean_bit_cnt", 64'(bit_cnt), 64'd88);
`endif

    // Single error
    send(1'b1);
    check("single_pulse", 64'(err_pulse), 64'd1);
    check("single_cnt", 64'(err_cnt), 64'd1);
    send(1'b0);
    check("single_pulse_gone", 64'(err_pulse), 64'd0);
    for (int i = 0; i < 10; i++) send(1'b0);
    check("single_cnt_hold", 64'(err_cnt), 64'd1);
    check("single_locked", 64'(locked), 64'd1);

    // Loss of lock after four consecutive errors, then relock
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
    for (int i = 0; i < 3; i++) send(1'b1);
    check("loss_still_locked", 64'(locked), 64'd1);
    send(1'b1);
    check("loss_unlocked", 64'(locked), 64'd0);
    check("loss_err_cnt", 64'(err_cnt), 64'd4);
    for (int i = 0; i < 11; i++) send(1'b0);
    check("relock_pre12", 64'(locked), 64'd0);
    send(1'b0);
    check("relock_at12", 64'(locked), 64'd1);

    // Disable while locked
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("disable_locked", 64'(locked), 64'd0);
    check("disable_err_held", 64'(err_cnt), 64'd4);

    // Gapped valid: lock point counts valid bits only
    for (int i = 0; i < 11; i++) begin send(1'b0); idle(); end
    check("gap_pre12", 64'(locked), 64'd0);
    send(1'b0);
    check("gap_at12", 64'(locked), 64'd1);
    idle();
    check("gap_idle_pulse", 64'(err_pulse), 64'd0);

    // Zero fault on all-zero history
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("zero_pre4", 64'(zero_fault), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("zero_at4", 64'(zero_fault), 64'd1);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("zero_no_lock", 64'(locked), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("zero_cleared", 64'(zero_fault), 64'd0);
    check("zero_err_cleared", 64'(err_cnt), 64'd0);

    // Saturation with 20 isolated errors
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) send(1'b0);
    check("sat_locked", 64'(locked), 64'd1);
    for (int i = 0; i < 20; i++) begin
      send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    end
    check("sat_err_cnt4", 64'(err_cnt4), 64'd15);
    check("sat_err_cnt16", 64'(err_cnt), 64'd20);
    check("sat_still_locked", 64'(locked), 64'd1);

    // Asynchronous reset mid-stream, between clock edges
    send(1'b1);
    check("pre_rst_pulse", 64'(err_pulse), 64'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_pulse", 64'(err_pulse), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_err_cnt4", 64'(err_cnt4), 64'd0);
    check("rst_zero_fault", 64'(zero_fault), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 12; i++) send(1'b0);
    check("post_rst_lock", 64'(locked), 64'd1);
    check("post_rst_err", 64'(err_cnt), 64'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
